// File: rtl/game_pkg.sv
// Shared game constants: screen limits, alien formation geometry and scoring.
// Also provides the helper that maps an alien's (row, col) to its alive-mask bit.
package game_pkg;

  localparam int X_MAX   = 159;
  localparam int Y_MAX   = 119;

  localparam int ROWS    = 3;
  localparam int COLS    = 8;
  localparam int ALIEN_W = 8;
  localparam int ALIEN_H = 6;
  localparam int X_STEP  = 12;
  localparam int Y_STEP  = 10;

  localparam int POINTS  = 10;
  localparam int SCORE_W = 16;

  localparam int ROW_W   = 2;
  localparam int COL_W   = 3;
  localparam int MASK_W  = ROWS * COLS;
  localparam int IDX_W   = $clog2(MASK_W);

  function automatic logic [IDX_W-1:0] cell_index(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
  endfunction

endpackage

// File: rtl/alien_cell_locator.sv
// Combinational locate logic: maps a laser offset from the formation origin
// to an alien cell, reporting whether the offset lands on a sprite.
import game_pkg::*;

module alien_cell_locator #(
  parameter int P_ROWS    = ROWS,
  parameter int P_COLS    = COLS,
  parameter int P_ALIEN_W = ALIEN_W,
  parameter int P_ALIEN_H = ALIEN_H,
  parameter int P_X_STEP  = X_STEP,
  parameter int P_Y_STEP  = Y_STEP
) (
  input  logic signed [8:0]       dx,
  input  logic signed [8:0]       dy,
  output logic                    in_cell,
  output logic [ROW_W-1:0]        row,
  output logic [COL_W-1:0]        col
);

  logic [7:0] x_off;
  logic [7:0] y_off;

  // Compare chains against step multiples replace a divider; the last
  // multiple not exceeding the offset picks the cell and its remainder.
  always_comb begin
    col   = '0;
    row   = '0;
    x_off = dx[7:0];
    y_off = dy[7:0];
    for (int c = 1; c < P_COLS; c++) begin
      if ({1'b0, dx[7:0]} >= 9'(c * P_X_STEP)) begin
        col   = COL_W'(c);
        x_off = dx[7:0] - 8'(c * P_X_STEP);
      end
    end
    for (int r = 1; r < P_ROWS; r++) begin
      if ({1'b0, dy[7:0]} >= 9'(r * P_Y_STEP)) begin
        row   = ROW_W'(r);
        y_off = dy[7:0] - 8'(r * P_Y_STEP);
      end
    end
    in_cell = !dx[8] && !dy[8]
              && ({1'b0, dx[7:0]} < 9'(P_COLS * P_X_STEP))
              && ({1'b0, dy[7:0]} < 9'(P_ROWS * P_Y_STEP))
              && (x_off < 8'(P_ALIEN_W))
              && (y_off < 8'(P_ALIEN_H));
  end

endmodule

// File: rtl/alien_hit_detector.sv
// Two-stage laser/alien collision detector: stage 1 locates the struck cell,
// stage 2 checks it against the alive mask, retires the alien and scores it.
import game_pkg::*;

module alien_hit_detector (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          x_laser,
  input  logic [6:0]          y_laser,
  input  logic                laser_active,
  input  logic [7:0]          grid_x,
  input  logic [6:0]          grid_y,
  input  logic                new_wave,
  output logic                hit,
  output logic [ROW_W-1:0]    hit_row,
  output logic [COL_W-1:0]    hit_col,
  output logic [MASK_W-1:0]   alive_mask,
  output logic                all_dead,
  output logic [SCORE_W-1:0]  score
);

  logic signed [8:0]   dx;
  logic signed [8:0]   dy;
  logic                loc_in_cell;
  logic [ROW_W-1:0]    loc_row;
  logic [COL_W-1:0]    loc_col;

  logic                s1_valid_q, s1_valid_d;
  logic [ROW_W-1:0]    s1_row_q, s1_row_d;
  logic [COL_W-1:0]    s1_col_q, s1_col_d;

  logic                hit_q, hit_d;
  logic [ROW_W-1:0]    hit_row_q, hit_row_d;
  logic [COL_W-1:0]    hit_col_q, hit_col_d;
  logic [MASK_W-1:0]   alive_q, alive_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W:0]    score_sum;
  logic [IDX_W-1:0]    s1_idx;

  assign dx = $signed({1'b0, x_laser}) - $signed({1'b0, grid_x});
  assign dy = $signed({2'b00, y_laser}) - $signed({2'b00, grid_y});

  alien_cell_locator u_locator (
    .dx      (dx),
    .dy      (dy),
    .in_cell (loc_in_cell),
    .row     (loc_row),
    .col     (loc_col)
  );

  assign s1_idx    = cell_index(s1_row_q, s1_col_q);
  assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(POINTS);

  // new_wave overrides a coincident hit so a freshly revived formation never
  // loses an alien to a shot aimed at the previous wave.
  always_comb begin
    s1_valid_d = laser_active && loc_in_cell;
    s1_row_d   = loc_row;
    s1_col_d   = loc_col;

    hit_d      = s1_valid_q && alive_q[s1_idx] && !new_wave;
    hit_row_d  = hit_row_q;
    hit_col_d  = hit_col_q;
    alive_d    = alive_q;
    score_d    = score_q;

    if (new_wave) begin
      alive_d = '1;
    end else if (hit_d) begin
      hit_row_d       = s1_row_q;
      hit_col_d       = s1_col_q;
      alive_d[s1_idx] = 1'b0;
      score_d         = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      hit_q      <= 1'b0;
      hit_row_q  <= '0;
      hit_col_q  <= '0;
      alive_q    <= '1;
      score_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_row_q   <= s1_row_d;
      s1_col_q   <= s1_col_d;
      hit_q      <= hit_d;
      hit_row_q  <= hit_row_d;
      hit_col_q  <= hit_col_d;
      alive_q    <= alive_d;
      score_q    <= score_d;
    end
  end

  assign hit        = hit_q;
  assign hit_row    = hit_row_q;
  assign hit_col    = hit_col_q;
  assign alive_mask = alive_q;
  assign all_dead   = (alive_q == '0);
  assign score      = score_q;

endmodule

// File: tb/tb_alien_hit_detector.sv
// Directed self-checking bench for alien_hit_detector (grid origin 20,10).
module tb_alien_hit_detector;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  x_laser;
  logic [6:0]  y_laser;
  logic        laser_active;
  logic [7:0]  grid_x;
  logic [6:0]  grid_y;
  logic        new_wave;
  logic        hit;
  logic [1:0]  hit_row;
  logic [2:0]  hit_col;
  logic [23:0] alive_mask;
  logic        all_dead;
  logic [15:0] score;

  int tests_run    = 0;
  int tests_failed = 0;

  alien_hit_detector dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .x_laser      (x_laser),
    .y_laser      (y_laser),
    .laser_active (laser_active),
    .grid_x       (grid_x),
    .grid_y       (grid_y),
    .new_wave     (new_wave),
    .hit          (hit),
    .hit_row      (hit_row),
    .hit_col      (hit_col),
    .alive_mask   (alive_mask),
    .all_dead     (all_dead),
    .score        (score)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    x_laser      = '0;
    y_laser      = '0;
    laser_active = 1'b0;
    grid_x       = 8'd20;
    grid_y       = 7'd10;
    new_wave     = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (hit !== 1'b0 || hit_row !== 2'd0 || hit_col !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_hit: hit=%b row=%0d col=%0d, required 0/0/0", hit, hit_row, hit_col);
    end
    tests_run++;
    if (alive_mask !== 24'hFFFFFF || all_dead !== 1'b0 || score !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: mask=%h all_dead=%b score=%0d, required ffffff/0/0", alive_mask, all_dead, score);
    end
  endtask

  task automatic test_centre_hit();
    do_reset();
    x_laser = 8'd45; y_laser = 7'd22; laser_active = 1'b1;
    step();
    laser_active = 1'b0;
    tests_run++;
    if (hit !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL centre_early: hit=%b after 1 clock, required 0", hit);
    end
    step();
    tests_run++;
    if (hit !== 1'b1 || hit_row !== 2'd1 || hit_col !== 3'd2) begin
      tests_failed++;
      $display("[TB] FAIL centre_hit: hit=%b row=%0d col=%0d, required 1/1/2", hit, hit_row, hit_col);
    end
    tests_run++;
    if (alive_mask !== 24'hFFFBFF || score !== 16'd10) begin
      tests_failed++;
      $display("[TB] FAIL centre_state: mask=%h score=%0d, required fffbff/10", alive_mask, score);
    end
    step();
    tests_run++;
    if (hit !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL centre_pulse: hit=%b one cycle later, required 0", hit);
    end
  endtask

  task automatic test_gap_outside();
    int hits = 0;
    do_reset();
    x_laser = 8'd30; y_laser = 7'd12; laser_active = 1'b1;
    step(); if (hit) hits++;
    x_laser = 8'd15;
    step(); if (hit) hits++;
    x_laser = 8'd45; y_laser = 7'd22; laser_active = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); if (hit) hits++;
    end
    tests_run++;
    if (hits != 0 || alive_mask !== 24'hFFFFFF || score !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL gap_outside: hits=%0d mask=%h score=%0d, required 0/ffffff/0", hits, alive_mask, score);
    end
  endtask

  task automatic test_dwell();
    int hits = 0;
    do_reset();
    x_laser = 8'd21; y_laser = 7'd11; laser_active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); if (hit) hits++;
    end
    laser_active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); if (hit) hits++;
    end
    tests_run++;
    if (hits != 1 || hit_row !== 2'd0 || hit_col !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL dwell_hits: hits=%0d row=%0d col=%0d, required 1/0/0", hits, hit_row, hit_col);
    end
    tests_run++;
    if (alive_mask !== 24'hFFFFFE || score !== 16'd10) begin
      tests_failed++;
      $display("[TB] FAIL dwell_state: mask=%h score=%0d, required fffffe/10", alive_mask, score);
    end
  endtask

  task automatic test_moving_grid();
    int hits = 0;
    logic [2:0] cols [3];
    logic [7:0] gx [3];
    gx[0] = 8'd20; gx[1] = 8'd26; gx[2] = 8'd38;
    cols[0] = 3'd7; cols[1] = 3'd7; cols[2] = 3'd7;
    do_reset();
    x_laser = 8'd45; y_laser = 7'd22; laser_active = 1'b1;
    for (int g = 0; g < 3; g++) begin
      grid_x = gx[g];
      for (int i = 0; i < 3; i++) begin
        step();
        if (hit) begin
          if (hits < 3) cols[hits] = hit_col;
          hits++;
        end
      end
    end
    laser_active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (hit) begin
        if (hits < 3) cols[hits] = hit_col;
        hits++;
      end
    end
    grid_x = 8'd20;
    tests_run++;
    if (hits != 3 || cols[0] !== 3'd2 || cols[1] !== 3'd1 || cols[2] !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL moving_grid_cols: hits=%0d cols=%0d,%0d,%0d, required 3 hits cols 2,1,0", hits, cols[0], cols[1], cols[2]);
    end
    tests_run++;
    if (alive_mask !== 24'hFFF8FF || score !== 16'd30) begin
      tests_failed++;
      $display("[TB] FAIL moving_grid_state: mask=%h score=%0d, required fff8ff/30", alive_mask, score);
    end
  endtask

  task automatic test_clear_wave();
    int hits = 0;
    do_reset();
    laser_active = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 8; c++) begin
        x_laser = 8'(21 + 12 * c);
        y_laser = 7'(11 + 10 * r);
        step();
        if (hit) hits++;
      end
    end
    laser_active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (hit) begin
        hits++;
        if (hits == 23) begin
          tests_run++;
          if (all_dead !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wave_not_dead: all_dead=%b with one alien left, required 0", all_dead);
          end
        end
      end
    end
    tests_run++;
    if (hits != 24 || score !== 16'd240) begin
      tests_failed++;
      $display("[TB] FAIL wave_hits: hits=%0d score=%0d, required 24/240", hits, score);
    end
    tests_run++;
    if (alive_mask !== 24'h000000 || all_dead !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL wave_all_dead: mask=%h all_dead=%b, required 000000/1", alive_mask, all_dead);
    end
    new_wave = 1'b1;
    step();
    new_wave = 1'b0;
    tests_run++;
    if (alive_mask !== 24'hFFFFFF || all_dead !== 1'b0 || score !== 16'd240) begin
      tests_failed++;
      $display("[TB] FAIL wave_revive: mask=%h all_dead=%b score=%0d, required ffffff/0/240", alive_mask, all_dead, score);
    end
    x_laser = 8'd21; y_laser = 7'd11; laser_active = 1'b1;
    step();
    laser_active = 1'b0;
    new_wave = 1'b1;
    step();
    new_wave = 1'b0;
    tests_run++;
    if (hit !== 1'b0 || alive_mask !== 24'hFFFFFF || score !== 16'd240) begin
      tests_failed++;
      $display("[TB] FAIL wave_override: hit=%b mask=%h score=%0d, required 0/ffffff/240", hit, alive_mask, score);
    end
    step();
    tests_run++;
    if (hit !== 1'b0 || alive_mask !== 24'hFFFFFF) begin
      tests_failed++;
      $display("[TB] FAIL wave_override_late: hit=%b mask=%h, required 0/ffffff", hit, alive_mask);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    x_laser = 8'd45; y_laser = 7'd22; laser_active = 1'b1;
    step();
    laser_active = 1'b0;
    step();
    step();
    tests_run++;
    if (score !== 16'd10 || alive_mask !== 24'hFFFBFF) begin
      tests_failed++;
      $display("[TB] FAIL async_pre: score=%0d mask=%h, required 10/fffbff", score, alive_mask);
    end
    x_laser = 8'd21; y_laser = 7'd11; laser_active = 1'b1;
    step();
    laser_active = 1'b0;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (hit !== 1'b0 || alive_mask !== 24'hFFFFFF || score !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL async_immediate: hit=%b mask=%h score=%0d, required 0/ffffff/0", hit, alive_mask, score);
    end
    #1;
    reset_n = 1'b1;
    step();
    tests_run++;
    if (hit !== 1'b0 || alive_mask !== 24'hFFFFFF || score !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL async_discard: hit=%b mask=%h score=%0d, required 0/ffffff/0", hit, alive_mask, score);
    end
  endtask

  initial begin
    test_reset();
    test_centre_hit();
    test_gap_outside();
    test_dwell();
    test_moving_grid();
    test_clear_wave();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
